uart_rx_fifo: RTL and testbench

Parametrised UART receive engine with a built-in receive FIFO, the next-generation RX path for the frequency counter's host link. It replaces the fixed 8-bit, single-byte receiver. Character width, parity mode and stop-bit count are selected at runtime, and every frame is majority-voted on a 16× oversampled line. Each frame is buffered with per-character error flags. It sits between the `uart_rx` pin and the Wishbone register slave, which drives its config inputs and pops its FIFO.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 49 ++++
 rtl/uart_rx_fifo.sv | 211 +++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Frame states, parity encodings and oversample sample points.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2
  } rx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int OVS = 16;
  localparam logic [3:0] SMP_A = 4'd7;
  localparam logic [3:0] SMP_B = 4'd8;
  localparam logic [3:0] SMP_C = 4'd9;
  localparam logic [3:0] TICK_LAST = 4'(OVS - 1);

  function automatic int entry_w(input int data_w);
    return data_w + 3;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Head data reads as zero while the FIFO is empty.
module sync_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr_q;
  logic [AW:0]  rptr_q;
  logic         do_push;
  logic         do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // A pop frees the slot a push into a full FIFO needs.
  assign do_push = push_i && (!full_o || do_pop);
  assign count_o = wptr_q - rptr_q;
  assign rdata_o = empty_o ? '0 : mem[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with runtime frame config, 3-sample majority
// voting on a 16x oversampled line and a buffered error-flag FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          uart_rx,
  input  logic                          rx_en_i,
  input  logic [DIV_W-1:0]              baud_div_i,
  input  logic [3:0]                    data_bits_i,
  input  logic [1:0]                    parity_i,
  input  logic                          two_stop_i,
  input  logic                          rd_i,
  input  logic                          clr_i,
  output logic [DATA_W-1:0]             dat_o,
  output logic                          perr_o,
  output logic                          ferr_o,
  output logic                          brk_o,
  output logic                          rx_valid_o,
  output logic                          full_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          overrun_o,
  output logic                          busy_o
);

  localparam int EW = entry_w(DATA_W);

  rx_state_e         state_q, state_d;
  logic              rx_meta, rx_s;
  logic [DIV_W-1:0]  div_q, div_cnt;
  logic [3:0]        tick_cnt, bit_cnt;
  logic [3:0]        nbits_q, nbits_in;
  logic [1:0]        par_q;
  logic              two_q;
  logic              s7, s8;
  logic              par_bit_q, ferr_q, ovr_q;
  logic [DATA_W-1:0] data_q;
  logic              tick, dec, bit_end, bit_val;
  logic              start_det, push, ferr_now;
  logic              perr, brk, par_en, fifo_empty;
  logic [EW-1:0]     entry, head;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
    end
  end

  always_comb begin
    unique case (1'b1)
      data_bits_i < 4'd5:         nbits_in = 4'd5;
      data_bits_i > 4'(DATA_W):   nbits_in = 4'(DATA_W);
      default:                    nbits_in = data_bits_i;
    endcase
  end

  assign tick    = (state_q != ST_IDLE) && (div_cnt == div_q);
  assign dec     = tick && (tick_cnt == SMP_C);
  assign bit_end = tick && (tick_cnt == TICK_LAST);
  assign bit_val = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
  assign par_en  = (par_q == PAR_EVEN) || (par_q == PAR_ODD);

  always_comb begin
    state_d   = state_q;
    start_det = 1'b0;
    push      = 1'b0;
    ferr_now  = ferr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_en_i && !rx_s) begin
          start_det = 1'b1;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (dec && bit_val) state_d = ST_IDLE;
        else if (bit_end)   state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end && bit_cnt == nbits_q - 4'd1)
          state_d = par_en ? ST_PARITY : ST_STOP1;
      end
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP1;
      end
      ST_STOP1: begin
        if (dec) begin
          ferr_now = ferr_q | !bit_val;
          if (!two_q) begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (bit_end) begin
          state_d = ST_STOP2;
        end
      end
      ST_STOP2: begin
        if (dec) begin
          ferr_now = ferr_q | !bit_val;
          push     = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Disabling the receiver drops the frame in flight.
    if (!rx_en_i && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      push    = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q     <= '0;
      div_cnt   <= '0;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      nbits_q   <= 4'd5;
      par_q     <= PAR_NONE;
      two_q     <= 1'b0;
      s7        <= 1'b1;
      s8        <= 1'b1;
      par_bit_q <= 1'b0;
      ferr_q    <= 1'b0;
      data_q    <= '0;
    end else if (start_det) begin
      div_q     <= baud_div_i;
      div_cnt   <= '0;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      nbits_q   <= nbits_in;
      par_q     <= parity_i;
      two_q     <= two_stop_i;
      par_bit_q <= 1'b0;
      ferr_q    <= 1'b0;
      data_q    <= '0;
    end else begin
      if (tick) begin
        div_cnt  <= '0;
        tick_cnt <= tick_cnt + 4'd1;
      end else if (state_q != ST_IDLE) begin
        div_cnt  <= div_cnt + 1'b1;
      end
      if (tick && tick_cnt == SMP_A) s7 <= rx_s;
      if (tick && tick_cnt == SMP_B) s8 <= rx_s;
      if (dec) begin
        unique case (state_q)
          ST_DATA: begin
            for (int i = 0; i < DATA_W; i++)
              if (bit_cnt == 4'(i)) data_q[i] <= bit_val;
          end
          ST_PARITY:          par_bit_q <= bit_val;
          ST_STOP1, ST_STOP2: ferr_q    <= ferr_now;
          default: ;
        endcase
      end
      if (bit_end && state_q == ST_DATA) bit_cnt <= bit_cnt + 4'd1;
    end
  end

  assign perr  = par_en &&
                 (par_bit_q ^ (^data_q) ^ (par_q == PAR_ODD));
  assign brk   = (data_q == '0) && ferr_now && !par_bit_q;
  assign entry = {brk, ferr_now, perr, data_q};

  // A pop in the same cycle makes room, so only a stalled push drops.
  always_ff @(posedge clk_i) begin
    if (rst_i)                       ovr_q <= 1'b0;
    else if (push && full_o && !rd_i) ovr_q <= 1'b1;
    else if (clr_i)                  ovr_q <= 1'b0;
  end

  sync_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (rd_i),
    .wdata_i (entry),
    .rdata_o (head),
    .count_o (count_o),
    .full_o  (full_o),
    .empty_o (fifo_empty)
  );

  assign dat_o      = head[DATA_W-1:0];
  assign perr_o     = head[DATA_W];
  assign ferr_o     = head[DATA_W+1];
  assign brk_o      = head[DATA_W+2];
  assign rx_valid_o = !fifo_empty;
  assign overrun_o  = ovr_q;
  assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: frames at baud_div 0
// (16 clocks per bit) into a 4-deep FIFO.
module tb_uart_rx_fifo;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        uart_rx = 1'b1;
  logic        rx_en_i = 1'b1;
  logic [15:0] baud_div_i = 16'd0;
  logic [3:0]  data_bits_i = 4'd8;
  logic [1:0]  parity_i = 2'b10;
  logic        two_stop_i = 1'b1;
  logic        rd_i = 1'b0;
  logic        clr_i = 1'b0;
  logic [7:0]  dat_o;
  logic        perr_o, ferr_o, brk_o;
  logic        rx_valid_o, full_o;
  logic [2:0]  count_o;
  logic        overrun_o, busy_o;

  int n_cmp = 0;
  int n_err = 0;

  uart_rx_fifo #(
    .DATA_W     (8),
    .FIFO_DEPTH (4),
    .DIV_W      (16)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .uart_rx     (uart_rx),
    .rx_en_i     (rx_en_i),
    .baud_div_i  (baud_div_i),
    .data_bits_i (data_bits_i),
    .parity_i    (parity_i),
    .two_stop_i  (two_stop_i),
    .rd_i        (rd_i),
    .clr_i       (clr_i),
    .dat_o       (dat_o),
    .perr_o      (perr_o),
    .ferr_o      (ferr_o),
    .brk_o       (brk_o),
    .rx_valid_o  (rx_valid_o),
    .full_o      (full_o),
    .count_o     (count_o),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    @(posedge clk_i);
    #1 uart_rx = b;
    repeat (15) @(posedge clk_i);
  endtask

  task automatic send(input logic [7:0] d, input int nb, input bit pe,
                      input logic pb, input int ns, input logic sv);
    drive_bit(1'b0);
    for (int i = 0; i < nb; i++) drive_bit(d[i]);
    if (pe) drive_bit(pb);
    for (int i = 0; i < ns; i++) drive_bit(sv);
    @(posedge clk_i);
    #1 uart_rx = 1'b1;
    repeat (48) @(posedge clk_i);
    #1;
  endtask

  task automatic pop;
    @(posedge clk_i);
    #1 rd_i = 1'b1;
    @(posedge clk_i);
    #1 rd_i = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_dat"},   32'(dat_o), 32'h0);
    chk({tag, "_flags"}, {29'd0, brk_o, ferr_o, perr_o}, 32'h0);
    chk({tag, "_valid"}, 32'(rx_valid_o), 32'h0);
    chk({tag, "_full"},  32'(full_o), 32'h0);
    chk({tag, "_count"}, 32'(count_o), 32'h0);
    chk({tag, "_ovr"},   32'(overrun_o), 32'h0);
    chk({tag, "_busy"},  32'(busy_o), 32'h0);
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(posedge clk_i);
    #1 chk_reset("rst");

    // 8 bits, odd parity, two stop: 0x39 with correct parity bit
    send(8'h39, 8, 1'b1, 1'b1, 2, 1'b1);
    chk("f39_dat", 32'(dat_o), 32'h39);
    chk("f39_flags", {29'd0, brk_o, ferr_o, perr_o}, 32'h0);
    chk("f39_valid", 32'(rx_valid_o), 32'h1);
    chk("f39_count", 32'(count_o), 32'h1);
    pop();
    chk("pop1_count", 32'(count_o), 32'h0);

    // 0xBB has six ones; odd parity wants 1, send 0
    send(8'hBB, 8, 1'b1, 1'b0, 2, 1'b1);
    chk("fbb_dat", 32'(dat_o), 32'hBB);
    chk("fbb_perr", 32'(perr_o), 32'h1);
    chk("fbb_ferr", 32'(ferr_o), 32'h0);
    pop();

    // 7 bits, no parity, one stop, stop bit held low
    data_bits_i = 4'd7;
    parity_i = 2'b00;
    two_stop_i = 1'b0;
    send(8'h55, 7, 1'b0, 1'b0, 1, 1'b0);
    chk("f55_dat", 32'(dat_o), 32'h55);
    chk("f55_ferr", 32'(ferr_o), 32'h1);
    chk("f55_brk", 32'(brk_o), 32'h0);
    chk("f55_count", 32'(count_o), 32'h1);
    pop();
    send(8'h00, 7, 1'b0, 1'b0, 1, 1'b0);
    chk("brk_dat", 32'(dat_o), 32'h0);
    chk("brk_flags", {29'd0, brk_o, ferr_o, perr_o}, 32'h6);
    chk("brk_busy", 32'(busy_o), 32'h0);
    pop();
    pop();
    chk("pop_empty_count", 32'(count_o), 32'h0);

    // overflow: five frames into a 4-deep FIFO
    data_bits_i = 4'd8;
    send(8'h11, 8, 1'b0, 1'b0, 1, 1'b1);
    send(8'h22, 8, 1'b0, 1'b0, 1, 1'b1);
    send(8'h33, 8, 1'b0, 1'b0, 1, 1'b1);
    send(8'h44, 8, 1'b0, 1'b0, 1, 1'b1);
    chk("ovf4_ovr", 32'(overrun_o), 32'h0);
    send(8'h55, 8, 1'b0, 1'b0, 1, 1'b1);
    chk("ovf_full", 32'(full_o), 32'h1);
    chk("ovf_count", 32'(count_o), 32'h4);
    chk("ovf_ovr", 32'(overrun_o), 32'h1);
    chk("ovf_head", 32'(dat_o), 32'h11);
    @(posedge clk_i);
    #1 clr_i = 1'b1;
    @(posedge clk_i);
    #1 clr_i = 1'b0;
    chk("clr_ovr", 32'(overrun_o), 32'h0);

    // push lands 156 edges after the start-bit edge; pop then too
    fork
      send(8'h66, 8, 1'b0, 1'b0, 1, 1'b1);
      begin
        @(posedge clk_i);
        repeat (156) @(posedge clk_i);
        #1 rd_i = 1'b1;
        @(posedge clk_i);
        #1 rd_i = 1'b0;
      end
    join
    chk("pp_count", 32'(count_o), 32'h4);
    chk("pp_ovr", 32'(overrun_o), 32'h0);
    chk("pp_head", 32'(dat_o), 32'h22);
    pop();
    chk("pp_d33", 32'(dat_o), 32'h33);
    pop();
    chk("pp_d44", 32'(dat_o), 32'h44);
    pop();
    chk("pp_tail", 32'(dat_o), 32'h66);
    pop();
    chk("drain_valid", 32'(rx_valid_o), 32'h0);
    chk("drain_dat", 32'(dat_o), 32'h0);

    // 3-clock glitch: false start rejected at tick 9
    @(posedge clk_i);
    #1 uart_rx = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 uart_rx = 1'b1;
    @(posedge clk_i);
    #1 chk("gl_busy_hi", 32'(busy_o), 32'h1);
    repeat (9) @(posedge clk_i);
    #1 chk("gl_busy_lo", 32'(busy_o), 32'h0);
    chk("gl_count", 32'(count_o), 32'h0);

    // reset in the middle of a frame flushes the FIFO
    send(8'h5A, 8, 1'b0, 1'b0, 1, 1'b1);
    chk("pre_rst_count", 32'(count_o), 32'h1);
    @(posedge clk_i);
    #1 uart_rx = 1'b0;
    repeat (40) @(posedge clk_i);
    #1 chk("mid_busy", 32'(busy_o), 32'h1);
    rst_i = 1'b1;
    uart_rx = 1'b1;
    @(posedge clk_i);
    #1 chk_reset("midrst");
    rst_i = 1'b0;
    repeat (4) @(posedge clk_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
